// File: rtl/xor_parity_checker_if.sv
// Frame input and result handshake bundle for xor_parity_checker.
// The checker takes the slave side; the producer/consumer take the master side.
interface xor_parity_checker_if #(
    parameter int WIDTH = 8,
    parameter int LEN_W = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_last;
    logic             in_par;
    logic             out_valid;
    logic             out_ready;
    logic             out_err;
    logic             out_len_err;
    logic [LEN_W-1:0] out_len;

    modport slave (
        input  in_valid, in_data, in_last, in_par, out_ready,
        output in_ready, out_valid, out_err, out_len_err, out_len
    );

    modport master (
        output in_valid, in_data, in_last, in_par, out_ready,
        input  in_ready, out_valid, out_err, out_len_err, out_len
    );
endinterface

// File: rtl/xor_parity_checker.sv
// Accumulates even parity and beat count over a frame, reports a registered
// result with length check, and keeps saturating good/bad frame totals.
module xor_parity_checker #(
    parameter  int WIDTH   = 8,
    parameter  int MAX_LEN = 16,
    parameter  int CNT_W   = 16,
    localparam int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    xor_parity_checker_if.slave  bus,
    output logic [CNT_W-1:0]     ok_cnt,
    output logic [CNT_W-1:0]     bad_cnt
);

    typedef enum logic [1:0] {IDLE, ACCUM, REPORT} state_t;

    state_t             state_q, state_d;
    logic               acc_q, acc_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic               ovf_q, ovf_d;
    logic               err_q, err_d;
    logic               len_err_q, len_err_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [CNT_W-1:0]   ok_q, ok_d;
    logic [CNT_W-1:0]   bad_q, bad_d;

    logic               in_ready;
    logic               out_valid;
    logic               beat_fire;
    logic               rpt_fire;
    logic               acc_nxt;
    logic [LEN_W-1:0]   cnt_nxt;
    logic               ovf_nxt;

    function automatic logic [LEN_W-1:0] sat_len_inc(input logic [LEN_W-1:0] v);
        return (v == LEN_W'(MAX_LEN)) ? v : v + LEN_W'(1);
    endfunction

    function automatic logic [CNT_W-1:0] sat_cnt_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign beat_fire = bus.in_valid && in_ready;
    assign rpt_fire  = out_valid && bus.out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE, ACCUM: if (beat_fire) state_d = bus.in_last ? REPORT : ACCUM;
            REPORT:      if (bus.out_ready) state_d = IDLE;
            default:     state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q != REPORT);
        out_valid = (state_q == REPORT);
    end

    // Overflow remembers that a beat arrived while the count was already pinned at MAX_LEN.
    always_comb begin
        acc_nxt   = acc_q ^ (^bus.in_data);
        cnt_nxt   = sat_len_inc(cnt_q);
        ovf_nxt   = ovf_q | (cnt_q == LEN_W'(MAX_LEN));

        acc_d     = acc_q;
        cnt_d     = cnt_q;
        ovf_d     = ovf_q;
        err_d     = err_q;
        len_err_d = len_err_q;
        len_d     = len_q;
        ok_d      = ok_q;
        bad_d     = bad_q;

        if (beat_fire) begin
            acc_d = acc_nxt;
            cnt_d = cnt_nxt;
            ovf_d = ovf_nxt;
            if (bus.in_last) begin
                err_d     = acc_nxt ^ bus.in_par;
                len_d     = cnt_nxt;
                len_err_d = ovf_nxt;
            end
        end

        if (rpt_fire) begin
            acc_d     = 1'b0;
            cnt_d     = '0;
            ovf_d     = 1'b0;
            err_d     = 1'b0;
            len_err_d = 1'b0;
            len_d     = '0;
            if (err_q || len_err_q) bad_d = sat_cnt_inc(bad_q);
            else                    ok_d  = sat_cnt_inc(ok_q);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q     <= 1'b0;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
            err_q     <= 1'b0;
            len_err_q <= 1'b0;
            len_q     <= '0;
            ok_q      <= '0;
            bad_q     <= '0;
        end else begin
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            ovf_q     <= ovf_d;
            err_q     <= err_d;
            len_err_q <= len_err_d;
            len_q     <= len_d;
            ok_q      <= ok_d;
            bad_q     <= bad_d;
        end
    end

    assign bus.in_ready    = in_ready;
    assign bus.out_valid   = out_valid;
    assign bus.out_err     = err_q;
    assign bus.out_len_err = len_err_q;
    assign bus.out_len     = len_q;
    assign ok_cnt          = ok_q;
    assign bad_cnt         = bad_q;

endmodule

// File: tb/tb_xor_parity_checker.sv
// Randomized and directed bench for xor_parity_checker, scored against a
// frame-level model (bit population parity, clipped length, frame totals).
module tb_xor_parity_checker;
    localparam int WIDTH   = 8;
    localparam int MAX_LEN = 16;
    localparam int CNT_W   = 16;
    localparam int LEN_W   = $clog2(MAX_LEN + 1);

    logic             clk = 1'b0;
    logic             reset;
    logic [CNT_W-1:0] ok_cnt;
    logic [CNT_W-1:0] bad_cnt;

    xor_parity_checker_if #(.WIDTH(WIDTH), .LEN_W(LEN_W)) bus ();

    xor_parity_checker #(.WIDTH(WIDTH), .MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus),
        .ok_cnt  (ok_cnt),
        .bad_cnt (bad_cnt)
    );

    always #5 clk = ~clk;

    int               checks = 0;
    int               errors = 0;
    logic [WIDTH-1:0] frame_q[$];
    int               m_ok = 0;
    int               m_bad = 0;
    bit               e_err;
    bit               e_lerr;
    int               e_len;

    // Frame-level expectation: total set bits (data + parity) must be even.
    task automatic model_frame(input bit par);
        int ones = int'(par);
        foreach (frame_q[i]) ones += $countones(frame_q[i]);
        e_err  = ones[0];
        e_len  = (frame_q.size() > MAX_LEN) ? MAX_LEN : frame_q.size();
        e_lerr = (frame_q.size() > MAX_LEN);
    endtask

    task automatic send_frame(input bit par, input bit with_last, input int gap_max);
        for (int i = 0; i < frame_q.size(); i++) begin
            int gaps = $urandom_range(gap_max, 0);
            repeat (gaps) begin
                bus.in_valid = 1'b0;
                @(posedge clk); #1;
            end
            bus.in_valid = 1'b1;
            bus.in_data  = frame_q[i];
            bus.in_last  = with_last && (i == frame_q.size() - 1);
            bus.in_par   = bus.in_last ? par : 1'($urandom);
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic handshake();
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        if (e_err || e_lerr) m_bad++;
        else                 m_ok++;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        m_ok  = 0;
        m_bad = 0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %0b want 0", bus.out_valid); end
        checks++; if (bus.out_err !== 1'b0) begin errors++; $display("FAIL rst_out_err got %0b want 0", bus.out_err); end
        checks++; if (bus.out_len_err !== 1'b0) begin errors++; $display("FAIL rst_out_len_err got %0b want 0", bus.out_len_err); end
        checks++; if (bus.out_len !== '0) begin errors++; $display("FAIL rst_out_len got %0d want 0", bus.out_len); end
        checks++; if (ok_cnt !== '0 || bad_cnt !== '0) begin errors++; $display("FAIL rst_counters got %0d/%0d want 0/0", ok_cnt, bad_cnt); end
        reset = 1'b0;
        m_ok  = 0;
        m_bad = 0;
        @(posedge clk); #1;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %0b want 1", bus.in_ready); end
    endtask

    task automatic test_good_frame();
        frame_q = '{8'h03, 8'h01, 8'h00};
        model_frame(1'b1);
        send_frame(1'b1, 1'b1, 0);
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL good_out_valid got %0b want 1", bus.out_valid); end
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL good_in_ready got %0b want 0", bus.in_ready); end
        checks++; if (bus.out_err !== 1'b0) begin errors++; $display("FAIL good_out_err got %0b want 0", bus.out_err); end
        checks++; if (bus.out_len !== LEN_W'(3)) begin errors++; $display("FAIL good_out_len got %0d want 3", bus.out_len); end
        handshake();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL good_valid_drop got %0b want 0", bus.out_valid); end
        checks++; if (ok_cnt !== CNT_W'(1) || bad_cnt !== '0) begin errors++; $display("FAIL good_counters got %0d/%0d want 1/0", ok_cnt, bad_cnt); end
    endtask

    task automatic test_bad_parity();
        frame_q = '{8'h03, 8'h01, 8'h00};
        model_frame(1'b0);
        send_frame(1'b0, 1'b1, 1);
        checks++; if (bus.out_err !== 1'b1) begin errors++; $display("FAIL badpar_out_err got %0b want 1", bus.out_err); end
        checks++; if (bus.out_len_err !== 1'b0) begin errors++; $display("FAIL badpar_len_err got %0b want 0", bus.out_len_err); end
        handshake();
        checks++; if (ok_cnt !== CNT_W'(m_ok) || bad_cnt !== CNT_W'(m_bad)) begin errors++; $display("FAIL badpar_counters got %0d/%0d want %0d/%0d", ok_cnt, bad_cnt, m_ok, m_bad); end
    endtask

    task automatic test_overlength();
        frame_q.delete();
        repeat (19) frame_q.push_back(8'h00);
        model_frame(1'b0);
        send_frame(1'b0, 1'b1, 0);
        checks++; if (bus.out_len !== LEN_W'(MAX_LEN)) begin errors++; $display("FAIL ovl_out_len got %0d want %0d", bus.out_len, MAX_LEN); end
        checks++; if (bus.out_len_err !== 1'b1) begin errors++; $display("FAIL ovl_len_err got %0b want 1", bus.out_len_err); end
        checks++; if (bus.out_err !== 1'b0) begin errors++; $display("FAIL ovl_out_err got %0b want 0", bus.out_err); end
        handshake();
        checks++; if (ok_cnt !== CNT_W'(m_ok) || bad_cnt !== CNT_W'(m_bad)) begin errors++; $display("FAIL ovl_counters got %0d/%0d want %0d/%0d", ok_cnt, bad_cnt, m_ok, m_bad); end
    endtask

    task automatic test_backpressure();
        logic [WIDTH-1:0] nxt = 8'hA5;
        bit               nxt_par = 1'b1;
        frame_q = '{8'h10, 8'h22, 8'h07, 8'h80};
        model_frame(1'b1);
        send_frame(1'b1, 1'b1, 0);
        bus.in_valid = 1'b1;
        bus.in_data  = nxt;
        bus.in_last  = 1'b1;
        bus.in_par   = nxt_par;
        for (int k = 0; k < 5; k++) begin
            checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready cyc %0d got %0b want 0", k, bus.in_ready); end
            checks++; if (bus.out_valid !== 1'b1 || bus.out_err !== e_err || bus.out_len !== LEN_W'(e_len))
                begin errors++; $display("FAIL bp_stable cyc %0d got v%0b e%0b l%0d want v1 e%0b l%0d", k, bus.out_valid, bus.out_err, bus.out_len, e_err, e_len); end
            @(posedge clk); #1;
        end
        handshake();
        checks++; if (ok_cnt !== CNT_W'(m_ok) || bad_cnt !== CNT_W'(m_bad)) begin errors++; $display("FAIL bp_counters got %0d/%0d want %0d/%0d", ok_cnt, bad_cnt, m_ok, m_bad); end
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_back got %0b want 1", bus.in_ready); end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        frame_q = '{nxt};
        model_frame(nxt_par);
        checks++; if (bus.out_valid !== 1'b1 || bus.out_len !== LEN_W'(1) || bus.out_err !== e_err)
            begin errors++; $display("FAIL bp_held_beat got v%0b l%0d e%0b want v1 l1 e%0b", bus.out_valid, bus.out_len, bus.out_err, e_err); end
        handshake();
    endtask

    task automatic test_reset_midframe();
        apply_reset();
        frame_q = '{8'h11, 8'h3C, 8'hF0, 8'h01};
        send_frame(1'b0, 1'b0, 0);
        reset = 1'b1;
        #2;
        checks++; if (bus.out_valid !== 1'b0 || bus.out_err !== 1'b0 || bus.out_len_err !== 1'b0 || bus.out_len !== '0)
            begin errors++; $display("FAIL mid_rst_outputs got v%0b e%0b le%0b l%0d want all 0", bus.out_valid, bus.out_err, bus.out_len_err, bus.out_len); end
        checks++; if (ok_cnt !== '0 || bad_cnt !== '0) begin errors++; $display("FAIL mid_rst_counters got %0d/%0d want 0/0", ok_cnt, bad_cnt); end
        @(posedge clk); #1;
        reset = 1'b0;
        m_ok  = 0;
        m_bad = 0;
        frame_q = '{8'hFF};
        model_frame(1'b0);
        send_frame(1'b0, 1'b1, 0);
        checks++; if (bus.out_err !== 1'b0 || bus.out_len !== LEN_W'(1)) begin errors++; $display("FAIL mid_single got e%0b l%0d want e0 l1", bus.out_err, bus.out_len); end
        handshake();
        checks++; if (ok_cnt !== CNT_W'(1) || bad_cnt !== '0) begin errors++; $display("FAIL mid_counters got %0d/%0d want 1/0", ok_cnt, bad_cnt); end
    endtask

    task automatic test_reset_in_report();
        frame_q = '{8'h01};
        model_frame(1'b0);
        send_frame(1'b0, 1'b1, 0);
        reset = 1'b1;
        #2;
        checks++; if (bus.out_valid !== 1'b0 || bus.out_err !== 1'b0) begin errors++; $display("FAIL rpt_rst got v%0b e%0b want v0 e0", bus.out_valid, bus.out_err); end
        checks++; if (ok_cnt !== '0 || bad_cnt !== '0) begin errors++; $display("FAIL rpt_rst_counters got %0d/%0d want 0/0", ok_cnt, bad_cnt); end
        @(posedge clk); #1;
        reset = 1'b0;
        m_ok  = 0;
        m_bad = 0;
    endtask

    task automatic test_random();
        for (int f = 0; f < 40; f++) begin
            int len  = $urandom_range(20, 1);
            int hold = $urandom_range(3, 0);
            bit par  = 1'($urandom);
            frame_q.delete();
            for (int b = 0; b < len; b++) frame_q.push_back(WIDTH'($urandom));
            model_frame(par);
            send_frame(par, 1'b1, (f % 3 == 0) ? 0 : 2);
            for (int k = 0; k <= hold; k++) begin
                checks++; if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.out_err !== e_err ||
                              bus.out_len_err !== e_lerr || bus.out_len !== LEN_W'(e_len))
                    begin errors++; $display("FAIL rnd_result f%0d got v%0b r%0b e%0b le%0b l%0d want v1 r0 e%0b le%0b l%0d",
                                             f, bus.out_valid, bus.in_ready, bus.out_err, bus.out_len_err, bus.out_len, e_err, e_lerr, e_len); end
                if (k < hold) begin @(posedge clk); #1; end
            end
            handshake();
            checks++; if (bus.out_valid !== 1'b0 || ok_cnt !== CNT_W'(m_ok) || bad_cnt !== CNT_W'(m_bad))
                begin errors++; $display("FAIL rnd_counters f%0d got v%0b %0d/%0d want v0 %0d/%0d", f, bus.out_valid, ok_cnt, bad_cnt, m_ok, m_bad); end
        end
    endtask

    initial begin
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_last   = 1'b0;
        bus.in_par    = 1'b0;
        bus.out_ready = 1'b0;
        #1;
        test_reset();
        test_good_frame();
        test_bad_parity();
        test_overlength();
        test_backpressure();
        test_reset_midframe();
        test_reset_in_report();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
